// File: rtl/count_report.sv
// Snapshots a 32-bit event count and reports it as "0x%08X\r\n" over a byte valid/busy handshake.
// Optional build macro COUNT_REPORT_CLEAR_EN adds a one-cycle counter clear pulse after each snapshot.
module count_report #(
  parameter int unsigned UPDATE_PERIOD = 100000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_count,
  input  logic        i_request,
  output logic        o_wr,
  output logic [7:0]  o_data,
  input  logic        i_busy,
  output logic        o_busy,
  output logic        o_clear
);

  localparam logic [31:0] TIMER_RELOAD = (UPDATE_PERIOD == 0) ? 32'd0 : 32'(UPDATE_PERIOD - 1);
  localparam logic [3:0]  LAST_INDEX   = 4'd11;

`ifdef COUNT_REPORT_CLEAR_EN
  localparam logic CLEAR_EN = 1'b1;
`else
  localparam logic CLEAR_EN = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [3:0]  index_q, index_d;
  logic        pending_q, pending_d;
  logic        wr_q, wr_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] timer_q, timer_d;
  logic        clear_q, clear_d;

  logic        expiry;
  logic        trigger;
  logic        accept;
  logic [3:0]  index_inc;

  assign expiry    = (UPDATE_PERIOD != 0) && (timer_q == 32'd0);
  assign trigger   = i_request || expiry;
  assign accept    = wr_q && !i_busy;
  assign index_inc = 4'(index_q + 4'd1);

  // Byte at a given position of the line; positions 2..9 walk the snapshot MS nibble first.
  function automatic logic [7:0] report_char(input logic [3:0] idx, input logic [31:0] value);
    logic [3:0] nib;
    logic [7:0] ch;
    nib = value[{3'(4'd9 - idx), 2'b00} +: 4];
    ch  = 8'h00;
    case (idx)
      4'd0:    ch = 8'h30;
      4'd1:    ch = 8'h78;
      4'd10:   ch = 8'h0D;
      4'd11:   ch = 8'h0A;
      default: begin
        if (idx <= 4'd9) begin
          ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end
      end
    endcase
    return ch;
  endfunction

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    index_d   = index_q;
    pending_d = pending_q;
    wr_d      = wr_q;
    data_d    = data_q;
    clear_d   = 1'b0;

    // Free-running period timer, independent of report activity.
    if (UPDATE_PERIOD == 0) begin
      timer_d = 32'd0;
    end else if (expiry) begin
      timer_d = TIMER_RELOAD;
    end else begin
      timer_d = timer_q - 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (pending_q || trigger) begin
          state_d   = SEND;
          shadow_d  = i_count;
          index_d   = 4'd0;
          pending_d = 1'b0;
          wr_d      = 1'b1;
          data_d    = 8'h30;
          clear_d   = CLEAR_EN;
        end
      end
      SEND: begin
        // Triggers during a report collapse into a single follow-on report.
        if (trigger) begin
          pending_d = 1'b1;
        end
        if (accept) begin
          if (index_q == LAST_INDEX) begin
            state_d = IDLE;
            wr_d    = 1'b0;
          end else begin
            index_d = index_inc;
            data_d  = report_char(index_inc, shadow_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      shadow_q  <= 32'd0;
      index_q   <= 4'd0;
      pending_q <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= 8'h00;
      timer_q   <= TIMER_RELOAD;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      index_q   <= index_d;
      pending_q <= pending_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      timer_q   <= timer_d;
      clear_q   <= clear_d;
    end
  end

  assign o_wr    = wr_q;
  assign o_data  = data_q;
  assign o_busy  = (state_q == SEND);
  assign o_clear = clear_q;

endmodule

// File: tb/tb_count_report.sv
// Self-checking bench for count_report: queue-based reference model plus directed literal checks.
// Instance A has periodic triggers disabled; instance B uses UPDATE_PERIOD=20.
module tb_count_report;

`ifdef COUNT_REPORT_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, busy_a, use_ctr, ev;
  logic [31:0] count_a, ctr;
  logic [31:0] icnt_a;
  logic        wr_a, obusy_a, clr_a;
  logic [7:0]  data_a;

  logic        rst_b, req_b, busy_b;
  logic [31:0] count_b;
  logic        wr_b, obusy_b, clr_b;
  logic [7:0]  data_b;

  assign icnt_a = use_ctr ? ctr : count_a;

  count_report #(.UPDATE_PERIOD(0)) u_a (
    .i_clk(clk), .i_reset(rst_a), .i_count(icnt_a), .i_request(req_a),
    .o_wr(wr_a), .o_data(data_a), .i_busy(busy_a), .o_busy(obusy_a), .o_clear(clr_a)
  );

  count_report #(.UPDATE_PERIOD(20)) u_b (
    .i_clk(clk), .i_reset(rst_b), .i_count(count_b), .i_request(req_b),
    .o_wr(wr_b), .o_data(data_b), .i_busy(busy_b), .o_busy(obusy_b), .o_clear(clr_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Event counter attached to instance A, cleared by o_clear.
  always @(posedge clk) begin
    if (rst_a)      ctr <= 32'd0;
    else if (clr_a) ctr <= 32'd0;
    else if (ev)    ctr <= ctr + 32'd1;
  end

  // Reference model for A: a report is the queue of bytes still owed.
  logic [7:0] q[$];
  logic [7:0] log_a[$];
  bit         pending_m = 1'b0;
  bit         clear_m = 1'b0;
  bit         model_live = 1'b0;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'(8'd48 + 8'(n)) : 8'(8'd55 + 8'(n));
  endfunction

  task automatic push_report(input logic [31:0] v);
    q.push_back(8'h30);
    q.push_back(8'h78);
    for (int i = 7; i >= 0; i--) q.push_back(hex_ascii(v[i*4 +: 4]));
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_live = 1'b1;
      if (!rst_a && wr_a && !busy_a) log_a.push_back(data_a);
      if (rst_a) begin
        q.delete();
        pending_m = 1'b0;
        clear_m   = 1'b0;
      end else begin
        clear_m = 1'b0;
        if (q.size() == 0) begin
          if (pending_m || req_a) begin
            push_report(icnt_a);
            pending_m = 1'b0;
            clear_m   = CLEAR_EN;
          end
        end else begin
          if (req_a) pending_m = 1'b1;
          if (!busy_a) void'(q.pop_front());
        end
      end
    end
  end

  int clr_cycles = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (clr_a) clr_cycles++;
      if (model_live) begin
        chk("cyc_wr", 32'(wr_a), 32'(q.size() > 0));
        chk("cyc_busy", 32'(obusy_a), 32'(q.size() > 0));
        chk("cyc_clear", 32'(clr_a), 32'(clear_m));
        if (q.size() > 0) chk("cyc_data", 32'(data_a), 32'(q[0]));
      end
    end
  end

  // Instance B monitors: edges since reset release, report start edges, run lengths.
  int eb = 0;
  int run_b = 0;
  bit prev_b = 1'b0;
  int starts_b[$];
  int runs_b[$];
  logic [7:0] log_b[$];

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_b && wr_b && !busy_b) log_b.push_back(data_b);
      if (rst_b) eb = 0;
      else eb++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        if (wr_b && !prev_b) starts_b.push_back(eb);
        if (wr_b) run_b++;
        else if (prev_b) begin
          runs_b.push_back(run_b);
          run_b = 0;
        end
        prev_b = wr_b;
      end
    end
  end

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_a.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (log_a.size() < n) chk("wait_log_timeout", 32'(log_a.size()), 32'(n));
  endtask

  task automatic pulse_req();
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
  endtask

  task automatic cmp_report(input string nm, input int base, input logic [95:0] e);
    logic [7:0] got;
    for (int i = 0; i < 12; i++) begin
      got = (base + i < log_a.size()) ? log_a[base + i] : 8'hxx;
      chk($sformatf("%s_b%0d", nm, i), 32'(got), 32'(e[95 - 8*i -: 8]));
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; busy_a = 1'b0;
    req_b = 1'b0; busy_b = 1'b0; count_b = 32'h12345678;
    count_a = 32'd0; use_ctr = 1'b0; ev = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr", 32'(wr_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'h00);
    chk("rst_busy", 32'(obusy_a), 32'd0);
    chk("rst_clear", 32'(clr_a), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Single request, free-flowing transmitter.
    count_a = 32'h0000BEEF;
    log_a.delete();
    @(negedge clk);
    pulse_req();
    wait_log(12);
    cmp_report("t1", 0, 96'h30_78_30_30_30_30_42_45_45_46_0D_0A);
    chk("t1_busy_after", 32'(obusy_a), 32'd0);
    $display("t1 report 0x0000BEEF: %0d bytes", log_a.size());

    // Transmitter stalls while byte index 3 is presented.
    repeat (3) @(negedge clk);
    count_a = 32'hFFFFFFFF;
    log_a.delete();
    pulse_req();
    wait_log(3);
    busy_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_wr", 32'(wr_a), 32'd1);
      chk("t2_hold_data", 32'(data_a), 32'h46);
      chk("t2_hold_cnt", 32'(log_a.size()), 32'd3);
    end
    busy_a = 1'b0;
    wait_log(12);
    cmp_report("t2", 0, 96'h30_78_46_46_46_46_46_46_46_46_0D_0A);
    $display("t2 stalled report 0xFFFFFFFF: %0d bytes", log_a.size());

    // Multiple requests mid-report give exactly one follow-on with the new count.
    repeat (3) @(negedge clk);
    count_a = 32'h00001111;
    log_a.delete();
    pulse_req();
    wait_log(4);
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      @(negedge clk);
    end
    count_a = 32'h00000010;
    wait_log(12);
    cmp_report("t3a", 0, 96'h30_78_30_30_30_30_31_31_31_31_0D_0A);
    chk("t3_gap_wr", 32'(wr_a), 32'd0);
    @(negedge clk);
    chk("t3_follow_wr", 32'(wr_a), 32'd1);
    chk("t3_follow_data", 32'(data_a), 32'h30);
    wait_log(24);
    cmp_report("t3b", 12, 96'h30_78_30_30_30_30_30_30_31_30_0D_0A);
    repeat (3) @(negedge clk);
    chk("t3_no_third", 32'(wr_a), 32'd0);
    $display("t3 follow-on reports: %0d bytes total", log_a.size());

    // Reset while byte index 5 is presented.
    count_a = 32'h000000A5;
    log_a.delete();
    pulse_req();
    wait_log(5);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("t4_wr_after_rst", 32'(wr_a), 32'd0);
    chk("t4_busy_after_rst", 32'(obusy_a), 32'd0);
    repeat (15) @(negedge clk);
    chk("t4_no_more_bytes", 32'(log_a.size()), 32'd5);
    log_a.delete();
    count_a = 32'h0BADF00D;
    pulse_req();
    wait_log(12);
    cmp_report("t4", 0, 96'h30_78_30_42_41_44_46_30_30_44_0D_0A);
    $display("t4 report after mid-report reset: %0d bytes", log_a.size());

    // Attached counter, 7 events, then a report.
    repeat (3) @(negedge clk);
    use_ctr = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      ev = 1'b1;
      @(negedge clk);
      ev = 1'b0;
      @(negedge clk);
    end
    clr_cycles = 0;
    log_a.delete();
    pulse_req();
    wait_log(12);
    cmp_report("t5", 0, 96'h30_78_30_30_30_30_30_30_30_37_0D_0A);
    repeat (2) @(negedge clk);
    chk("t5_clear_cycles", 32'(clr_cycles), CLEAR_EN ? 32'd1 : 32'd0);
    chk("t5_counter", ctr, CLEAR_EN ? 32'd0 : 32'd7);
    $display("t5 counter report: clear cycles %0d, counter %0d", clr_cycles, ctr);

    // Periodic reports on instance B.
    chk("b_starts_n", 32'(starts_b.size() >= 3), 32'd1);
    if (starts_b.size() >= 3) begin
      chk("b_start0", 32'(starts_b[0]), 32'd20);
      chk("b_start1", 32'(starts_b[1]), 32'd40);
      chk("b_start2", 32'(starts_b[2]), 32'd60);
    end
    chk("b_runs_n", 32'(runs_b.size() >= 3), 32'd1);
    for (int i = 0; i < 3 && i < runs_b.size(); i++) chk($sformatf("b_run%0d", i), 32'(runs_b[i]), 32'd12);
    chk("b_bytes_n", 32'(log_b.size() >= 12), 32'd1);
    if (log_b.size() >= 12) begin
      for (int i = 0; i < 12; i++) begin
        logic [95:0] eb_lit;
        eb_lit = 96'h30_78_31_32_33_34_35_36_37_38_0D_0A;
        chk($sformatf("b_byte%0d", i), 32'(log_b[i]), 32'(eb_lit[95 - 8*i -: 8]));
      end
    end
    $display("periodic: %0d reports started", starts_b.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_report.md
# count_report

Periodic and on-demand reporter for a 32-bit event count. Latches a snapshot of the count from an event counter and sends it as a 12-byte ASCII line, "0x" + 8 uppercase hex digits + CR LF, to a byte-wide serial transmitter through a valid/busy handshake. It sits between the event counter and the UART transmitter and decides when the count is reported. Optionally, it clears the counter on each snapshot.

## Interface
- UPDATE_PERIOD, default 100000000: clocks between periodic report triggers; 0 disables periodic triggers.
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_count  in  32  count value from the event counter
- i_request  in  1  report request; one-cycle pulse or level, sampled every clock
- o_wr  out  1  byte valid to transmitter
- o_data  out  8  byte to transmit
- i_busy  in  1  transmitter busy; a byte is accepted on a clock where o_wr && !i_busy
- o_busy  out  1  report in progress (state SEND)
- o_clear  out  1  counter clear pulse (see Configuration)

## Operation
- Reset values: state IDLE, o_wr=0, o_data=8'h00, o_busy=0, o_clear=0, pending=0, index=0, timer=UPDATE_PERIOD-1.
- Trigger sources are i_request and timer expiry.
- Timer:
  - Counts down each clock and reloads to UPDATE_PERIOD-1 when it reaches 0.
  - The clock where timer==0 is an expiry.
  - The timer runs freely; it is not paused by reports.
- State machine with two states, IDLE and SEND.
- IDLE → SEND occurs on a clock where (pending || i_request || expiry). On that edge:
  - shadow <= i_count.
  - index <= 0.
  - pending <= 0.
  - o_wr <= 1, o_data <= 8'h30 ('0').
- SEND, on accept:
  - If index==11: go to IDLE and set o_wr <= 0.
  - Otherwise: index <= index+1 and o_data <= char(index+1).
- SEND, no accept: o_wr and o_data are held stable.
- Trigger while in SEND, or on the SEND→IDLE edge: sets pending. Pending is one-deep, so any number of triggers during a report yields exactly one follow-on report.
- Byte sequence by index:
  - 0: 0x30 ('0')
  - 1: 0x78 ('x')
  - 2..9: hex nibbles of shadow, most-significant nibble first. Values 0-9 map to 0x30-0x39; values A-F map to 0x41-0x46.
  - 10: 0x0D (CR)
  - 11: 0x0A (LF)
- The snapshot is i_count as sampled at the latch edge. Changes to i_count during the report are ignored.
- o_data is don't-care while o_wr=0. It holds its last value and does not return to 8'h00.

## Timing
- Latency: a trigger sampled at edge k gives o_wr=1 with the first byte from edge k on, and shadow equals i_count at edge k.
- With i_busy=0 throughout, one byte is sent per clock: o_wr is high for exactly 12 consecutive cycles.
- Between back-to-back reports, o_wr is low for exactly one cycle (the IDLE cycle).
- o_busy equals (state==SEND) and is asserted and deasserted on the same edges as o_wr.
- Reset mid-report: on the next cycle o_wr=0 and state is IDLE. No further bytes are sent, and pending and the timer are reinitialised.
- Reset has priority over all triggers on the same edge.

## Configuration
- COUNT_REPORT_CLEAR_EN defined:
  - o_clear is registered and high for exactly one cycle following each latch edge, concurrent with the first o_wr cycle.
  - The counter clears on the next edge.
  - Events on the latch edge and on the clear edge are lost; at most 2 per report. This loss is specified behaviour.
- COUNT_REPORT_CLEAR_EN not defined: o_clear is constant 0. The counter is never cleared, and reports show a running total.

## Test plan
- Reset, i_count=32'h0000BEEF, i_busy=0, one i_request pulse.
  - o_wr high for 12 consecutive cycles with bytes 30 78 30 30 30 30 42 45 45 46 0D 0A.
  - o_busy is then 0.
- i_count=32'hFFFFFFFF, i_busy held high for 5 cycles while byte index 3 is presented.
  - o_wr and o_data (0x46) stay stable for those cycles.
  - No byte is skipped or duplicated, and all 12 bytes arrive.
- During a report, pulse i_request 3 times, then change i_count to 32'h00000010 before the report ends.
  - Exactly one follow-on report, "0x00000010\r\n", preceded by exactly one o_wr-low cycle.
- UPDATE_PERIOD=20, no requests, i_busy=0.
  - The first report starts at the edge 20 clocks after reset release, then every 20 clocks.
  - Each report is 12 bytes.
- Assert i_reset while byte index 5 is presented.
  - o_wr=0 on the next cycle and no further bytes.
  - A later i_request produces a full report from byte '0'.
- COUNT_REPORT_CLEAR_EN with a counter attached and 7 events counted, then i_request.
  - Report shows 0x00000007.
  - o_clear is high for exactly one cycle and the counter then reads 0.
  - Without the macro, o_clear stays 0 and the counter keeps 7.
